shape_sequencer: RTL and testbench
==================================

# shape_sequencer

Controller that sequences the shape renderer's 2-bit shape selection from the fkey/bkey/mkey push buttons. It debounces the keys and holds requested changes until the start of a frame, so the on-screen shape never switches mid-frame. It also offers an auto-cycle slideshow mode. It sits between the board buttons and the shape renderer's select input, clocked by the pixel/system clock and fed a frame-start strobe from the VGA sync generator.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive identical synchronized samples required to accept a new key level (10 ms at 50 MHz).
- DWELL_FRAMES, 120: frames each shape is shown in auto mode; legal range 1..4095.
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- fkey  in  1  forward button, active-low (0 = pressed), asynchronous to clk.
- bkey  in  1  backward button, active-low, asynchronous.
- mkey  in  1  mode button (manual/auto toggle), active-low, asynchronous.
- frame_start  in  1  single-cycle strobe at start of vertical blanking.
- shape_sel  out  2  committed shape: 0 RECT, 1 SQUARE, 2 CIRCLE, 3 TRIANGLE.
- pending  out  1  high while the requested selection differs from shape_sel.
- auto_mode  out  1  high while auto-cycle is active.
- commit  out  1  single-cycle pulse in the cycle shape_sel takes a new value.

## Operation
- Reset (resetn = 0 at a clk edge): shape_sel = 0, next_sel = 0, pending = 0, auto_mode = 0, commit = 0, dwell_cnt = 0, debounce counters = 0. Synchronizer flops and debounced levels reset to 1 (released).
- Per key:
  - 2-flop synchronizer feeds the debouncer.
  - The debouncer counter increments while the synchronized sample differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips.
  - A key event is a 1-cycle pulse on the debounced 0→1 transition, i.e. on release. Holding a key produces one event only.
- next_sel register:
  - f event alone: next_sel + 1 mod 4 (3 wraps to 0).
  - b event alone: next_sel − 1 mod 4 (0 wraps to 3).
  - f and b events in the same cycle cancel; next_sel is unchanged.
  - Multiple events between frames accumulate in next_sel.
- m event toggles auto_mode. Leaving auto mode clears dwell_cnt. Any pending request is kept.
- Control FSM, states IDLE (next_sel == shape_sel) and PEND (next_sel != shape_sel). pending = (state == PEND).
  - IDLE→PEND: a key event makes next_sel differ.
  - PEND→IDLE: net-zero events return next_sel to shape_sel; no commit occurs.
  - PEND→IDLE at frame_start: shape_sel ← next_sel, commit = 1, dwell_cnt ← 0.
- Auto mode, at each frame_start:
  - If PEND: the pending commit takes priority.
  - Else if dwell_cnt == DWELL_FRAMES−1: shape_sel and next_sel ← shape_sel + 1 mod 4, commit = 1, dwell_cnt ← 0.
  - Else: dwell_cnt + 1.
  - dwell_cnt is 12 bits unsigned.
- Manual mode: dwell_cnt holds at 0; only PEND commits occur.

## Timing
- Key edge to event pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles. Bounces shorter than DEBOUNCE_CYCLES are rejected.
- Key event to next_sel/pending: next_sel and pending are registered, visible on the edge after the event pulse.
- Commit latency: shape_sel, commit and the FSM update on the clk edge that samples frame_start = 1. shape_sel is stable for the entire following frame.
- A key event in the same cycle as frame_start is not part of that commit. It lands in next_sel and commits at the following frame_start.
- commit is high for exactly one cycle per committed change. It is never asserted for a no-change frame.
- Reset asserted mid-debounce or with a request pending discards all state. The first cycle after reset release shows the reset values.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, DWELL_FRAMES = 3.
- Reset: hold resetn = 0 for 3 cycles with keys toggling → shape_sel = 0, pending = 0, auto_mode = 0, commit = 0. Keys at 1 for 10 cycles after release → no events.
- Bounce: fkey low for 3 cycles, then a clean press of 20 cycles and release → only the clean press counts. pending = 1. At next frame_start, shape_sel = 1 and commit pulses once.
- Wrap and accumulate: from 0, two b releases before a frame → next_sel = 2. At frame_start, shape_sel = 2. Then f, f → next_sel = 0 (wrap), committed at the next frame_start.
- Cancel cases:
  - f then b before a frame → pending returns to 0; no commit at frame_start.
  - f and b event pulses in the same cycle → next_sel unchanged.
- Frame collision: f event in the same cycle as frame_start → no commit on that frame. shape_sel = 1 after the following frame_start.
- Auto mode: mkey release, then 6 frame_starts → shape_sel goes 0→1 on the 3rd and 1→2 on the 6th. A manual b release before frame 2 commits at frame 2 and restarts dwell_cnt. A second mkey release → auto_mode = 0 and no further auto advance.

Source files
------------

// File: rtl/shape_sequencer.sv
// shape_sequencer: debounced key-driven 2-bit shape select with frame-aligned commits
// and an auto-cycle slideshow mode.
module shape_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fkey,
  input  logic       bkey,
  input  logic       mkey,
  input  logic       frame_start,
  output logic [1:0] shape_sel,
  output logic       pending,
  output logic       auto_mode,
  output logic       commit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0] DWELL_MAX = 12'(DWELL_FRAMES - 1);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync2_q, lvl_q, lvl_d, ev;
  logic [1:0] sel_q, sel_d, nsel_q, nsel_d;
  logic [11:0] dwell_q, dwell_d;
  logic auto_q, auto_d, commit_q, commit_d;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      lvl_q   <= '1;
    end else begin
      sync1_q <= {mkey, bkey, fkey};
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
    end
  end
  // bit 0 = forward, 1 = backward, 2 = mode; events fire on debounced release
  for (genvar k = 0; k < 3; k++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic flip;
    assign flip = (sync2_q[k] != lvl_q[k]) && (cnt_q == CNT_MAX);
    assign cnt_d = (sync2_q[k] == lvl_q[k] || flip) ? '0 : cnt_q + 1'b1;
    assign lvl_d[k] = lvl_q[k] ^ flip;
    assign ev[k] = flip & ~lvl_q[k];
    always_ff @(posedge clk) begin
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
  end
  always_comb begin
    sel_d    = sel_q;
    nsel_d   = nsel_q;
    dwell_d  = dwell_q;
    commit_d = 1'b0;
    auto_d   = auto_q ^ ev[2];
    if (frame_start && state_q == PEND) begin
      sel_d    = nsel_q;
      commit_d = 1'b1;
      dwell_d  = '0;
    end else if (frame_start && auto_q) begin
      if (dwell_q == DWELL_MAX) begin
        sel_d    = sel_q + 2'd1;
        nsel_d   = sel_q + 2'd1;
        commit_d = 1'b1;
        dwell_d  = '0;
      end else dwell_d = dwell_q + 12'd1;
    end
    // same-cycle key events land after any commit, so they wait for the next frame
    nsel_d  = nsel_d + {ev[1] & ~ev[0], ev[0] ^ ev[1]};
    dwell_d = auto_d ? dwell_d : '0;
    state_d = (nsel_d != sel_d) ? PEND : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      nsel_q   <= '0;
      dwell_q  <= '0;
      auto_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      nsel_q   <= nsel_d;
      dwell_q  <= dwell_d;
      auto_q   <= auto_d;
      commit_q <= commit_d;
    end
  end
  assign shape_sel = sel_q;
  assign pending   = (state_q == PEND);
  assign auto_mode = auto_q;
  assign commit    = commit_q;
endmodule

// File: tb/tb_shape_sequencer.sv
// tb_shape_sequencer: directed scoreboard bench for shape_sequencer with short
// debounce (4) and dwell (3) settings.
module tb_shape_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic fkey = 1'b1, bkey = 1'b1, mkey = 1'b1, frame_start = 1'b0;
  logic [1:0] shape_sel;
  logic pending, auto_mode, commit;
  int vectors = 0, errors = 0, ncommit = 0, exp_commits = 0;
  typedef struct {
    string      tag;
    logic [1:0] sel;
    logic       pend;
    logic       auto_m;
    int         com;
  } exp_t;
  exp_t sb[$];
  shape_sequencer #(.DEBOUNCE_CYCLES(4), .DWELL_FRAMES(3)) dut (
    .clk(clk), .resetn(resetn), .fkey(fkey), .bkey(bkey), .mkey(mkey),
    .frame_start(frame_start), .shape_sel(shape_sel), .pending(pending),
    .auto_mode(auto_mode), .commit(commit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (commit === 1'b1) ncommit++;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_key(input int k, input logic v);
    if (k == 0) fkey = v;
    else if (k == 1) bkey = v;
    else mkey = v;
  endtask
  task automatic press(input int k, input int hold);
    @(negedge clk) set_key(k, 1'b0);
    cyc(hold);
    set_key(k, 1'b1);
    cyc(12);
  endtask
  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    cyc(3);
  endtask
  task automatic expect_st(input string tag, input logic [1:0] s, input logic p, input logic a);
    sb.push_back('{tag, s, p, a, exp_commits});
  endtask
  task automatic check();
    exp_t e;
    e = sb.pop_front();
    vectors += 4;
    assert (shape_sel === e.sel) else begin
      errors++;
      $error("FAIL %s shape_sel got %0d want %0d", e.tag, shape_sel, e.sel);
    end
    assert (pending === e.pend) else begin
      errors++;
      $error("FAIL %s pending got %0b want %0b", e.tag, pending, e.pend);
    end
    assert (auto_mode === e.auto_m) else begin
      errors++;
      $error("FAIL %s auto_mode got %0b want %0b", e.tag, auto_mode, e.auto_m);
    end
    assert (ncommit === e.com) else begin
      errors++;
      $error("FAIL %s commit_count got %0d want %0d", e.tag, ncommit, e.com);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fkey = ~fkey; bkey = ~bkey; mkey = ~mkey;
    end
    expect_st("reset_hold", 2'd0, 1'b0, 1'b0); check();
    vectors++;
    assert (commit === 1'b0) else begin
      errors++;
      $error("FAIL reset_commit got %0b want 0", commit);
    end
    fkey = 1'b1; bkey = 1'b1; mkey = 1'b1; resetn = 1'b1;
    cyc(1);
    expect_st("reset_release", 2'd0, 1'b0, 1'b0); check();
    cyc(10);
    expect_st("idle_keys", 2'd0, 1'b0, 1'b0); check();
    @(negedge clk) fkey = 1'b0;
    cyc(3);
    fkey = 1'b1;
    cyc(2);
    press(0, 20);
    expect_st("bounce_pend", 2'd0, 1'b1, 1'b0); check();
    frame(); exp_commits++;
    expect_st("bounce_commit", 2'd1, 1'b0, 1'b0); check();
    press(0, 20);
    expect_st("pend_before_rst", 2'd1, 1'b1, 1'b0); check();
    @(negedge clk) fkey = 1'b0;
    cyc(3);
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1; fkey = 1'b1;
    cyc(1);
    expect_st("rst_discard", 2'd0, 1'b0, 1'b0); check();
    cyc(10);
    expect_st("rst_quiet", 2'd0, 1'b0, 1'b0); check();
    press(1, 20);
    press(1, 20);
    expect_st("bb_pend", 2'd0, 1'b1, 1'b0); check();
    frame(); exp_commits++;
    expect_st("bb_commit", 2'd2, 1'b0, 1'b0); check();
    press(0, 20);
    press(0, 20);
    expect_st("ff_pend", 2'd2, 1'b1, 1'b0); check();
    frame(); exp_commits++;
    expect_st("ff_wrap", 2'd0, 1'b0, 1'b0); check();
    press(0, 20);
    press(1, 20);
    expect_st("fb_cancel", 2'd0, 1'b0, 1'b0); check();
    frame();
    expect_st("fb_nocommit", 2'd0, 1'b0, 1'b0); check();
    @(negedge clk) begin fkey = 1'b0; bkey = 1'b0; end
    cyc(20);
    fkey = 1'b1; bkey = 1'b1;
    cyc(12);
    expect_st("fb_same_cycle", 2'd0, 1'b0, 1'b0); check();
    frame();
    expect_st("fb_same_frame", 2'd0, 1'b0, 1'b0); check();
    @(negedge clk) fkey = 1'b0;
    cyc(20);
    fkey = 1'b1;
    cyc(5);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    cyc(3);
    expect_st("collide_hold", 2'd0, 1'b1, 1'b0); check();
    frame(); exp_commits++;
    expect_st("collide_next", 2'd1, 1'b0, 1'b0); check();
    @(negedge clk) resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    expect_st("auto_rst", 2'd0, 1'b0, 1'b0); check();
    press(2, 20);
    expect_st("auto_on", 2'd0, 1'b0, 1'b1); check();
    frame(); frame();
    expect_st("auto_f2", 2'd0, 1'b0, 1'b1); check();
    frame(); exp_commits++;
    expect_st("auto_f3", 2'd1, 1'b0, 1'b1); check();
    frame(); frame();
    expect_st("auto_f5", 2'd1, 1'b0, 1'b1); check();
    frame(); exp_commits++;
    expect_st("auto_f6", 2'd2, 1'b0, 1'b1); check();
    frame();
    press(1, 20);
    expect_st("auto_b_pend", 2'd2, 1'b1, 1'b1); check();
    frame(); exp_commits++;
    expect_st("auto_b_commit", 2'd1, 1'b0, 1'b1); check();
    frame(); frame();
    expect_st("auto_dwell_restart", 2'd1, 1'b0, 1'b1); check();
    frame(); exp_commits++;
    expect_st("auto_advance", 2'd2, 1'b0, 1'b1); check();
    press(2, 20);
    expect_st("auto_off", 2'd2, 1'b0, 1'b0); check();
    frame(); frame(); frame(); frame();
    expect_st("manual_hold", 2'd2, 1'b0, 1'b0); check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
